uart_host_ctrl: RTL and testbench



---
 rtl/uart_host_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_host_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_ctrl.sv
// Host-side controller for a UART core: buffers bytes in TX/RX FIFOs and runs the core handshakes.
// Defining UART_HOST_STATS_EN adds the tx_count/rx_count/drop_count statistics outputs.

module uart_host_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // A simultaneous pop frees the slot on a full FIFO; a pop on an empty FIFO is ignored.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end
endmodule

module uart_host_ctrl #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int BUSY_TO  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] uart_data_in,
    output logic       uart_wr_en,
    input  logic       uart_busy,
    input  logic [7:0] uart_data_out,
    input  logic       uart_rdy,
    output logic       uart_rdy_clr,
    output logic       rx_overflow,
    output logic       tx_timeout
`ifdef UART_HOST_STATS_EN
    ,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
    output logic [15:0] drop_count
`endif
);
    localparam int TW = ($clog2(BUSY_TO) > 0) ? $clog2(BUSY_TO) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TO - 1);
    localparam logic [TW-1:0] TIMER_ONE  = 1;

    typedef enum logic [1:0] {TX_IDLE, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;
    typedef enum logic       {RX_IDLE, RX_CLR_WAIT} rx_state_t;

    tx_state_t     tx_state;
    tx_state_t     tx_next;
    rx_state_t     rx_state;
    rx_state_t     rx_next;

    logic          tx_full;
    logic          tx_empty;
    logic [7:0]    tx_head;
    logic          tx_push;
    logic          tx_start;
    logic          tx_expire;
    logic [TW-1:0] tx_timer;
    logic          timer_done;

    logic          rx_full;
    logic          rx_empty;
    logic          rx_pop;
    logic          rx_capture;
    logic          rx_store;
    logic          rx_drop;

    assign tx_ready   = !tx_full;
    assign tx_push    = tx_valid && tx_ready;
    assign rx_valid   = !rx_empty;
    assign rx_pop     = rx_ready && rx_valid;
    assign timer_done = (tx_timer == TIMER_LAST);

    uart_host_fifo #(.DEPTH(TX_DEPTH)) tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_start),
        .din   (tx_data),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    uart_host_fifo #(.DEPTH(RX_DEPTH)) rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_store),
        .pop   (rx_pop),
        .din   (uart_data_out),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty && !uart_busy) tx_next = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (uart_busy)       tx_next = TX_WAIT_DONE;
                else if (timer_done) tx_next = TX_IDLE;
            end
            TX_WAIT_DONE: begin
                if (!uart_busy) tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_start  = 1'b0;
        tx_expire = 1'b0;
        case (tx_state)
            TX_IDLE:      tx_start  = !tx_empty && !uart_busy;
            TX_WAIT_BUSY: tx_expire = !uart_busy && timer_done;
            default: ;
        endcase
    end

    // Strobe and data are registered; the byte on uart_data_in stays put until the next strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_wr_en   <= 1'b0;
            uart_data_in <= 8'h00;
            tx_timer     <= '0;
            tx_timeout   <= 1'b0;
        end else begin
            uart_wr_en <= tx_start;
            if (tx_start) begin
                uart_data_in <= tx_head;
                tx_timer     <= '0;
            end else if (tx_state == TX_WAIT_BUSY && !timer_done) begin
                tx_timer <= tx_timer + TIMER_ONE;
            end
            if (tx_expire) tx_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    // CLR_WAIT blocks a lingering uart_rdy from being captured a second time.
    always_comb begin
        rx_next = rx_state;
        if (rx_state == RX_IDLE) begin
            if (uart_rdy) rx_next = RX_CLR_WAIT;
        end else begin
            if (!uart_rdy) rx_next = RX_IDLE;
        end
    end

    always_comb begin
        rx_capture = (rx_state == RX_IDLE) && uart_rdy;
        rx_store   = rx_capture && (!rx_full || rx_pop);
        rx_drop    = rx_capture && !rx_store;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_rdy_clr <= 1'b0;
            rx_overflow  <= 1'b0;
        end else begin
            uart_rdy_clr <= rx_capture;
            if (rx_drop) rx_overflow <= 1'b1;
        end
    end

`ifdef UART_HOST_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_count   <= 16'h0000;
            rx_count   <= 16'h0000;
            drop_count <= 16'h0000;
        end else begin
            tx_count   <= tx_count + 16'(tx_start);
            rx_count   <= rx_count + 16'(rx_store);
            drop_count <= drop_count + 16'(rx_drop) + 16'(tx_expire);
        end
    end
`endif

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Self-checking bench for uart_host_ctrl: a UART core model plus queue-based reference model.
module tb_uart_host_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] uart_data_in;
    logic       uart_wr_en;
    logic       uart_busy;
    logic [7:0] uart_data_out;
    logic       uart_rdy;
    logic       uart_rdy_clr;
    logic       rx_overflow;
    logic       tx_timeout;

    uart_host_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16), .BUSY_TO(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .uart_data_in  (uart_data_in),
        .uart_wr_en    (uart_wr_en),
        .uart_busy     (uart_busy),
        .uart_data_out (uart_data_out),
        .uart_rdy      (uart_rdy),
        .uart_rdy_clr  (uart_rdy_clr),
        .rx_overflow   (rx_overflow),
        .tx_timeout    (tx_timeout)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int accept_cyc = 0;

    bit force_busy = 0;
    bit core_resp = 1;
    int busy_len = 100;
    int busy_left = 0;
    int fall_cyc = -1;
    int clr_count = 0;

    logic [7:0] strobe_q[$];
    int         strobe_cyc[$];
    logic [7:0] tx_model[$];
    logic [7:0] rx_model[$];

    always @(posedge clk) cyc++;

    // Core model: logs strobes, answers with busy, counts rdy_clr pulses.
    always @(negedge clk) begin
        bit next_busy;
        if (rst) begin
            busy_left = 0;
            uart_busy = 1'b0;
        end else begin
            if (uart_wr_en) begin
                strobe_q.push_back(uart_data_in);
                strobe_cyc.push_back(cyc);
                if (core_resp) busy_left = busy_len;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            next_busy = force_busy || (busy_left > 0);
            if (uart_busy === 1'b1 && !next_busy) fall_cyc = cyc;
            uart_busy = next_busy;
            if (uart_rdy_clr) clr_count++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        bit ok = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (tx_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                accept_cyc = cyc;
                tx_model.push_back(b);
            end else begin
                @(negedge clk);
            end
        end
        tx_valid = 1'b0;
        checkOutput("tx_accept", 32'(ok), 1);
    endtask

    task automatic waitStrobes(input int n);
        for (int i = 0; i < 3000 && strobe_q.size() < n; i++) @(negedge clk);
        checkOutput("strobe_count", strobe_q.size(), n);
    endtask

    task automatic compareTx();
        int n;
        checkOutput("tx_stream_len", strobe_q.size(), tx_model.size());
        n = (strobe_q.size() < tx_model.size()) ? strobe_q.size() : tx_model.size();
        for (int i = 0; i < n; i++) checkOutput("tx_byte", strobe_q[i], tx_model[i]);
        strobe_q.delete();
        strobe_cyc.delete();
        tx_model.delete();
    endtask

    task automatic deliverByte(input logic [7:0] b);
        bit got = 0;
        @(negedge clk);
        uart_data_out = b;
        uart_rdy      = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (uart_rdy_clr) got = 1;
        end
        uart_rdy = 1'b0;
        if (rx_model.size() < 16) rx_model.push_back(b);
        checkOutput("rdy_clr_seen", 32'(got), 1);
        @(negedge clk);
    endtask

    task automatic drainRx();
        logic [7:0] e;
        while (rx_model.size() > 0) begin
            @(negedge clk);
            rx_ready = 1'b1;
            e = rx_model.pop_front();
            checkOutput("rx_valid", 32'(rx_valid), 1);
            checkOutput("rx_data", 32'(rx_data), 32'(e));
        end
        @(negedge clk);
        rx_ready = 1'b0;
        checkOutput("rx_empty", 32'(rx_valid), 0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_tx_ready"}, 32'(tx_ready), 1);
        checkOutput({tag, "_rx_valid"}, 32'(rx_valid), 0);
        checkOutput({tag, "_rx_data"}, 32'(rx_data), 0);
        checkOutput({tag, "_wr_en"}, 32'(uart_wr_en), 0);
        checkOutput({tag, "_data_in"}, 32'(uart_data_in), 0);
        checkOutput({tag, "_rdy_clr"}, 32'(uart_rdy_clr), 0);
        checkOutput({tag, "_overflow"}, 32'(rx_overflow), 0);
        checkOutput({tag, "_timeout"}, 32'(tx_timeout), 0);
    endtask

    initial begin
        int first_strobe;
        int c0;
        int clr0;
        logic [7:0] b;
        logic [7:0] b2;

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        uart_rdy = 1'b0; uart_data_out = 8'h00;
        repeat (3) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;

        $display("[TB] two back-to-back host writes");
        busy_len = 100;
        fall_cyc = -1;
        applyStimulus(8'hA5);
        applyStimulus(8'h3C);
        waitStrobes(2);
        checkOutput("s2_spacing",
            (strobe_cyc.size() > 1) ? 32'((fall_cyc > strobe_cyc[0]) && (strobe_cyc[1] > fall_cyc)) : 32'(0), 1);
        compareTx();
        for (int i = 0; i < 500 && uart_busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);

        $display("[TB] fill TX FIFO while busy held");
        force_busy = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) applyStimulus(8'($urandom));
        @(negedge clk);
        checkOutput("tx_full_ready", 32'(tx_ready), 0);
        checkOutput("no_strobe_while_busy", strobe_q.size(), 0);
        b = 8'($urandom);
        tx_data  = b;
        tx_valid = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("tx17_blocked", 32'(tx_ready), 0);
        busy_len   = 3;
        force_busy = 0;
        accept_cyc = -1;
        for (int i = 0; i < 200 && accept_cyc < 0; i++) begin
            if (tx_ready) begin
                @(posedge clk);
                #1;
                accept_cyc = cyc;
                tx_model.push_back(b);
            end else begin
                @(negedge clk);
            end
        end
        tx_valid = 1'b0;
        first_strobe = (strobe_cyc.size() > 0) ? strobe_cyc[0] : 32'h7fffffff;
        checkOutput("tx17_after_pop", 32'((accept_cyc >= 0) && (accept_cyc > first_strobe)), 1);
        waitStrobes(17);
        compareTx();
        repeat (10) @(negedge clk);

        $display("[TB] single receive with lingering rdy");
        clr0 = clr_count;
        @(negedge clk);
        uart_data_out = 8'h5A;
        uart_rdy      = 1'b1;
        @(negedge clk);
        checkOutput("rx1_rdy_clr", 32'(uart_rdy_clr), 1);
        checkOutput("rx1_valid", 32'(rx_valid), 1);
        checkOutput("rx1_data", 32'(rx_data), 32'h5A);
        repeat (3) @(negedge clk);
        uart_rdy = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rx1_clr_pulses", clr_count - clr0, 1);
        rx_model.push_back(8'h5A);
        drainRx();

        $display("[TB] RX overflow");
        clr0 = clr_count;
        for (int i = 0; i < 16; i++) deliverByte(8'(i));
        checkOutput("ovf_before", 32'(rx_overflow), 0);
        deliverByte(8'h10);
        checkOutput("ovf_after", 32'(rx_overflow), 1);
        checkOutput("ovf_clr_pulses", clr_count - clr0, 17);
        drainRx();

        $display("[TB] TX busy timeout");
        core_resp = 0;
        b  = 8'($urandom);
        b2 = 8'($urandom);
        applyStimulus(b);
        applyStimulus(b2);
        waitStrobes(1);
        c0 = (strobe_cyc.size() > 0) ? strobe_cyc[0] : cyc;
        while (cyc < c0 + 7) @(negedge clk);
        checkOutput("timeout_early", 32'(tx_timeout), 0);
        @(negedge clk);
        checkOutput("timeout_set", 32'(tx_timeout), 1);
        waitStrobes(2);
        checkOutput("strobe_after_timeout",
            (strobe_cyc.size() > 1) ? 32'(strobe_cyc[1] > c0 + 8) : 32'(0), 1);
        repeat (12) @(negedge clk);
        checkOutput("data_in_hold", 32'(uart_data_in), 32'(b2));
        core_resp = 1;
        compareTx();

        $display("[TB] reset during WAIT_DONE");
        busy_len = 40;
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom));
        repeat (10) @(negedge clk);
        checkOutput("pre_rst_busy", 32'(uart_busy), 1);
        rst = 1'b1;
        #1;
        checkReset("midrst");
        checkOutput("pre_rst_strobes", strobe_q.size(), 1);
        strobe_q.delete();
        strobe_cyc.delete();
        tx_model.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        checkOutput("no_strobe_after_rst", strobe_q.size(), 0);
        applyStimulus(8'($urandom));
        waitStrobes(1);
        compareTx();
        for (int i = 0; i < 200 && uart_busy; i++) @(negedge clk);

        $display("[TB] push and pop on full RX FIFO");
        clr0 = clr_count;
        for (int i = 0; i < 16; i++) deliverByte(8'($urandom));
        b = 8'($urandom);
        @(negedge clk);
        uart_data_out = b;
        uart_rdy      = 1'b1;
        rx_ready      = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checkOutput("fullpop_clr", 32'(uart_rdy_clr), 1);
        uart_rdy = 1'b0;
        void'(rx_model.pop_front());
        rx_model.push_back(b);
        @(negedge clk);
        checkOutput("fullpop_no_ovf", 32'(rx_overflow), 0);
        checkOutput("fullpop_clr_pulses", clr_count - clr0, 17);
        drainRx();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
